// File: rtl/demux_3b_1to4_buf_pkg.sv
// demux_3b_1to4_buf_pkg: shared select codes and channel state type
package demux_3b_1to4_buf_pkg;
  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;
  typedef enum logic {EMPTY, FULL} chan_state_e;
endpackage

// File: rtl/demux_3b_1to4_buf_if.sv
// demux_3b_1to4_buf_if: producer input stream and four consumer channels
interface demux_3b_1to4_buf_if #(parameter int WIDTH = 3, parameter int CNT_W = 8);
  logic en;
  logic [1:0] se;
  logic [WIDTH-1:0] x;
  logic x_valid;
  logic x_ready;
  logic [WIDTH-1:0] ya, yb, yc, yd;
  logic [3:0] y_valid;
  logic [3:0] y_ready;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c, cnt_d;
  modport master(
    output en, se, x, x_valid, y_ready,
    input x_ready, ya, yb, yc, yd, y_valid, cnt_a, cnt_b, cnt_c, cnt_d
  );
  modport slave(
    input en, se, x, x_valid, y_ready,
    output x_ready, ya, yb, yc, yd, y_valid, cnt_a, cnt_b, cnt_c, cnt_d
  );
endinterface

// File: rtl/demux_chan_buf.sv
// demux_chan_buf: one-entry output register with valid/ready and delivered-word counter
module demux_chan_buf
  import demux_3b_1to4_buf_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] cnt
);
  chan_state_e state, nxt;
  logic drain;
  assign valid = state == FULL;
  assign drain = valid & ready;
  // load wins over drain so a same-cycle drain+reload stays FULL
  always_comb nxt = load ? FULL : drain ? EMPTY : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      dout  <= '0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (load) dout <= din;
      if (drain) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/demux_3b_1to4_buf.sv
// demux_3b_1to4_buf: buffered 1-to-4 demux steering each accepted word to channel se
module demux_3b_1to4_buf
  import demux_3b_1to4_buf_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst,
  demux_3b_1to4_buf_if.slave bus
);
  logic acc;
  logic [3:0] load;
  assign bus.x_ready = bus.en & (~bus.y_valid[bus.se] | bus.y_ready[bus.se]);
  assign acc = bus.x_valid & bus.x_ready;
  assign load = {acc & (bus.se == SEL_D), acc & (bus.se == SEL_C),
                 acc & (bus.se == SEL_B), acc & (bus.se == SEL_A)};
  demux_chan_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_a (
    .clk(clk), .rst(rst), .load(load[0]), .din(bus.x), .valid(bus.y_valid[0]),
    .ready(bus.y_ready[0]), .dout(bus.ya), .cnt(bus.cnt_a)
  );
  demux_chan_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_b (
    .clk(clk), .rst(rst), .load(load[1]), .din(bus.x), .valid(bus.y_valid[1]),
    .ready(bus.y_ready[1]), .dout(bus.yb), .cnt(bus.cnt_b)
  );
  demux_chan_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_c (
    .clk(clk), .rst(rst), .load(load[2]), .din(bus.x), .valid(bus.y_valid[2]),
    .ready(bus.y_ready[2]), .dout(bus.yc), .cnt(bus.cnt_c)
  );
  demux_chan_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_d (
    .clk(clk), .rst(rst), .load(load[3]), .din(bus.x), .valid(bus.y_valid[3]),
    .ready(bus.y_ready[3]), .dout(bus.yd), .cnt(bus.cnt_d)
  );
endmodule

// File: tb/tb_demux_3b_1to4_buf.sv
// tb_demux_3b_1to4_buf: directed-vector bench for the buffered 1-to-4 demux
module tb_demux_3b_1to4_buf;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  demux_3b_1to4_buf_if #(.WIDTH(3), .CNT_W(8)) bus ();
  demux_3b_1to4_buf #(.WIDTH(3), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.en = 1;
    bus.se = 2'b00;
    bus.x = 3'b101;
    bus.x_valid = 1;
    bus.y_ready = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid", {28'd0, bus.y_valid}, 0);
      check("rst_data", {20'd0, bus.ya, bus.yb, bus.yc, bus.yd}, 0);
      check("rst_cnt", {bus.cnt_a, bus.cnt_b, bus.cnt_c, bus.cnt_d}, 0);
    end
    rst = 0;
    bus.y_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.se = 2'(i);
      tick();
      check("route_walk", {28'd0, bus.y_valid}, 32'(1 << i));
    end
    bus.x_valid = 0;
    tick();
    check("route_empty", {28'd0, bus.y_valid}, 0);
    check("route_data", {20'd0, bus.ya, bus.yb, bus.yc, bus.yd}, 32'b101101101101);
    check("route_cnt", {bus.cnt_a, bus.cnt_b, bus.cnt_c, bus.cnt_d}, 32'h01010101);
    bus.y_ready = 4'b1011;
    bus.se = 2'b10;
    bus.x = 3'b011;
    bus.x_valid = 1;
    #1;
    check("bp_ready1", {31'd0, bus.x_ready}, 1);
    tick();
    bus.x = 3'b110;
    #1;
    check("bp_stall", {31'd0, bus.x_ready}, 0);
    tick();
    check("bp_hold", {29'd0, bus.yc}, 3'b011);
    check("bp_valid", {28'd0, bus.y_valid}, 4'b0100);
    bus.y_ready = 4'b1111;
    #1;
    check("bp_ready2", {31'd0, bus.x_ready}, 1);
    tick();
    bus.y_ready = 4'b1011;
    bus.x_valid = 0;
    check("bp_reload", {29'd0, bus.yc}, 3'b110);
    check("bp_full", {28'd0, bus.y_valid}, 4'b0100);
    check("bp_cnt_c", {24'd0, bus.cnt_c}, 2);
    bus.se = 2'b00;
    bus.x = 3'b111;
    bus.x_valid = 1;
    #1;
    check("nb_ready", {31'd0, bus.x_ready}, 1);
    tick();
    check("nb_ya", {29'd0, bus.ya}, 3'b111);
    check("nb_valid", {28'd0, bus.y_valid}, 4'b0101);
    check("nb_yc", {29'd0, bus.yc}, 3'b110);
    bus.y_ready = 4'b1001;
    bus.se = 2'b01;
    bus.x = 3'b010;
    tick();
    check("en_pre", {28'd0, bus.y_valid}, 4'b0110);
    check("en_cnt_a", {24'd0, bus.cnt_a}, 2);
    bus.en = 0;
    bus.se = 2'b11;
    bus.x = 3'b100;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.y_ready = 4'b1011;
      #1;
      check("en_block", {31'd0, bus.x_ready}, 0);
      tick();
      check("en_valid", {28'd0, bus.y_valid}, i == 2 ? 4'b0100 : 4'b0110);
    end
    check("en_yd", {29'd0, bus.yd}, 3'b101);
    check("en_yb", {29'd0, bus.yb}, 3'b010);
    check("en_cnt_b", {24'd0, bus.cnt_b}, 2);
    bus.en = 1;
    bus.x_valid = 0;
    bus.y_ready = 4'b1111;
    tick();
    check("drain_c", {24'd0, bus.cnt_c}, 3);
    bus.se = 2'b11;
    bus.x_valid = 1;
    for (int i = 0; i < 255; i++) begin
      bus.x = 3'(i);
      tick();
    end
    bus.x_valid = 0;
    check("wrap_pre", {24'd0, bus.cnt_d}, 255);
    check("wrap_valid", {28'd0, bus.y_valid}, 4'b1000);
    check("wrap_yd", {29'd0, bus.yd}, 3'b110);
    tick();
    check("wrap_zero", {24'd0, bus.cnt_d}, 0);
    check("wrap_empty", {28'd0, bus.y_valid}, 0);
    bus.y_ready = 4'b0000;
    bus.se = 2'b00;
    bus.x = 3'b001;
    bus.x_valid = 1;
    tick();
    bus.x_valid = 0;
    check("mid_full", {28'd0, bus.y_valid}, 4'b0001);
    rst = 1;
    tick();
    rst = 0;
    check("mid_rst_valid", {28'd0, bus.y_valid}, 0);
    check("mid_rst_ya", {29'd0, bus.ya}, 0);
    check("mid_rst_cnt", {bus.cnt_a, bus.cnt_b, bus.cnt_c, bus.cnt_d}, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
